// File: rtl/interrupt_unit_pkg.sv
// Shared types for the interrupt unit: FSM states, source ids, request record.
// Encodings are fixed so the state and source fields read the same in every waveform.
package interrupt_unit_pkg;

  localparam int NUM_BP    = 4;
  localparam int BP_IDX_W  = $clog2(NUM_BP);
  localparam int VEC_W     = 32;
  localparam int PAYLOAD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_BP = 2'd0,
    SRC_IR = 2'd1,
    SRC_KB = 2'd2
  } src_e;

  typedef struct packed {
    src_e                 src;
    logic [VEC_W-1:0]     vector;
    logic [PAYLOAD_W-1:0] data;
  } int_req_t;

  // Lowest set bit wins when several breakpoints match the same PC.
  function automatic logic [BP_IDX_W-1:0] lowest_idx(input logic [NUM_BP-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = BP_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/interrupt_unit_fifo.sv
// Small synchronous FIFO for keyboard codes; head is visible without a pop.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module interrupt_unit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/interrupt_unit.sv
// Breakpoint / IR / keyboard interrupt arbiter feeding one request to the core.
// Request handshake: IDLE -> REQ (until intAck) -> ACTIVE (until intDone) -> IDLE.
module interrupt_unit
  import interrupt_unit_pkg::*;
#(
  parameter int KB_DEPTH = 4,
  parameter int CODE_W   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [VEC_W-1:0]     i_pc,
  input  logic                 i_pcValid,
  input  logic [VEC_W-1:0]     i_bp0Addr,
  input  logic [VEC_W-1:0]     i_bp1Addr,
  input  logic [VEC_W-1:0]     i_bp2Addr,
  input  logic [VEC_W-1:0]     i_bp3Addr,
  input  logic                 i_bp0En,
  input  logic                 i_bp1En,
  input  logic                 i_bp2En,
  input  logic                 i_bp3En,
  input  logic [VEC_W-1:0]     i_bpAddr,
  input  logic [VEC_W-1:0]     i_irAddr,
  input  logic                 i_irEn,
  input  logic                 i_irPulse,
  input  logic [VEC_W-1:0]     i_keyboardAddr,
  input  logic                 i_keyboardEn,
  input  logic                 i_kbValid,
  input  logic [CODE_W-1:0]    i_kbCode,
  output logic                 o_kbReady,
  output logic                 o_intReq,
  output logic [VEC_W-1:0]     o_intVector,
  output logic [PAYLOAD_W-1:0] o_intData,
  input  logic                 i_intAck,
  input  logic                 i_intDone
);

  logic [NUM_BP-1:0][VEC_W-1:0] w_bpAddrs;
  logic [NUM_BP-1:0]            w_bpEn;
  logic [NUM_BP-1:0]            w_bpHit;

  state_e                r_state;
  state_e                w_next;
  int_req_t              r_cur;
  int_req_t              w_win;
  logic                  r_intReq;
  logic                  r_bpPend;
  logic [BP_IDX_W-1:0]   r_bpIdx;
  logic                  r_irPend;
  logic                  w_latch;
  logic                  w_take;
  logic                  w_bpSet;
  logic                  w_irSet;

  logic                  w_kbFull;
  logic                  w_kbEmpty;
  logic [CODE_W-1:0]     w_kbHead;
  logic                  w_kbPush;
  logic                  w_kbPop;
  logic                  w_kbElig;

  assign w_bpAddrs = {i_bp3Addr, i_bp2Addr, i_bp1Addr, i_bp0Addr};
  assign w_bpEn    = {i_bp3En, i_bp2En, i_bp1En, i_bp0En};

  for (genvar g = 0; g < NUM_BP; g++) begin : g_bp
    assign w_bpHit[g] = i_pcValid && w_bpEn[g] && (i_pc == w_bpAddrs[g]);
  end

  // A breakpoint is only armed from a quiet IDLE; hits during service are lost.
  assign w_bpSet = (|w_bpHit) && !r_bpPend && (r_state == ST_IDLE);
  assign w_irSet = i_irPulse && i_irEn;

  // With the keyboard disabled the FIFO still drains the producer, dropping codes.
  assign o_kbReady = !w_kbFull || !i_keyboardEn;
  assign w_kbPush  = i_kbValid && i_keyboardEn && !w_kbFull;
  assign w_kbPop   = w_take && (r_cur.src == SRC_KB);
  assign w_kbElig  = !w_kbEmpty && i_keyboardEn;

  interrupt_unit_fifo #(
    .DEPTH (KB_DEPTH),
    .WIDTH (CODE_W)
  ) u_kb_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_kbPush),
    .i_pop   (w_kbPop),
    .i_din   (i_kbCode),
    .o_full  (w_kbFull),
    .o_empty (w_kbEmpty),
    .o_head  (w_kbHead)
  );

  always_comb begin
    w_win.src    = SRC_KB;
    w_win.vector = i_keyboardAddr;
    w_win.data   = PAYLOAD_W'(w_kbHead);
    if (r_bpPend) begin
      w_win.src    = SRC_BP;
      w_win.vector = i_bpAddr;
      w_win.data   = PAYLOAD_W'(r_bpIdx);
    end else if (r_irPend) begin
      w_win.src    = SRC_IR;
      w_win.vector = i_irAddr;
      w_win.data   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_take  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_bpPend || r_irPend || w_kbElig) begin
          w_next  = ST_REQ;
          w_latch = 1'b1;
        end
      end
      ST_REQ: begin
        if (i_intAck) begin
          w_next = ST_ACTIVE;
          w_take = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (i_intDone) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // A fresh event on the source being acknowledged keeps its flag set.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_intReq <= 1'b0;
      r_cur    <= '0;
      r_bpPend <= 1'b0;
      r_bpIdx  <= '0;
      r_irPend <= 1'b0;
    end else begin
      if (w_latch) begin
        r_intReq <= 1'b1;
        r_cur    <= w_win;
      end else if (w_take) begin
        r_intReq <= 1'b0;
      end

      if (w_bpSet) begin
        r_bpPend <= 1'b1;
        r_bpIdx  <= lowest_idx(w_bpHit);
      end else if (w_take && (r_cur.src == SRC_BP)) begin
        r_bpPend <= 1'b0;
      end

      if (w_irSet)                                  r_irPend <= 1'b1;
      else if (w_take && (r_cur.src == SRC_IR))     r_irPend <= 1'b0;
    end
  end

  assign o_intReq    = r_intReq;
  assign o_intVector = r_cur.vector;
  assign o_intData   = r_cur.data;

endmodule

// File: tb/tb_interrupt_unit.sv
// Scoreboarded bench for interrupt_unit: directed scenarios then random traffic,
// predicted by a rule-level model of pending events, a code queue and a service phase.
module tb_interrupt_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pcValid;
  logic [31:0] bpa [4];
  logic        bpe [4];
  logic [31:0] bpAddr, irAddr, kbAddr;
  logic        irEn, irPulse, kbEn, kbValid;
  logic [7:0]  kbCode;
  logic        kbReady, intReq, intAck, intDone;
  logic [31:0] intVector;
  logic [15:0] intData;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] v; logic [15:0] d; } exp_t;
  exp_t sbq[$];

  // model: phase 0 = nothing offered, 1 = request offered, 2 = handler running
  bit         m_bp, m_ir, m_kbAcc;
  int         m_bpIdx, m_phase, m_src;
  logic [7:0] m_kbq[$];

  logic        mon_prev;
  exp_t        mon_cur;
  logic [31:0] addrs [4];

  always #5 clk = ~clk;

  interrupt_unit #(.KB_DEPTH(4), .CODE_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_pcValid(pcValid),
    .i_bp0Addr(bpa[0]), .i_bp1Addr(bpa[1]), .i_bp2Addr(bpa[2]), .i_bp3Addr(bpa[3]),
    .i_bp0En(bpe[0]), .i_bp1En(bpe[1]), .i_bp2En(bpe[2]), .i_bp3En(bpe[3]),
    .i_bpAddr(bpAddr), .i_irAddr(irAddr), .i_irEn(irEn), .i_irPulse(irPulse),
    .i_keyboardAddr(kbAddr), .i_keyboardEn(kbEn), .i_kbValid(kbValid), .i_kbCode(kbCode),
    .o_kbReady(kbReady), .o_intReq(intReq), .o_intVector(intVector), .o_intData(intData),
    .i_intAck(intAck), .i_intDone(intDone)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_bp = 0; m_ir = 0; m_kbAcc = 0; m_phase = 0; m_src = 0; m_bpIdx = 0;
    m_kbq.delete();
    sbq.delete();
  endfunction

  // Apply the rules for the coming clock edge using the inputs now on the pins.
  function automatic void model_step();
    int hit = -1;
    int ph  = m_phase;
    bit ob  = m_bp;
    m_kbAcc = kbValid && ((m_kbq.size() < 4) || !kbEn);
    for (int n = 3; n >= 0; n--)
      if (pcValid && bpe[n] && (pc == bpa[n])) hit = n;
    if (ph == 0) begin
      if (m_bp) begin
        sbq.push_back('{bpAddr, 16'(m_bpIdx)}); m_src = 0; m_phase = 1;
      end else if (m_ir) begin
        sbq.push_back('{irAddr, 16'h0000}); m_src = 1; m_phase = 1;
      end else if ((m_kbq.size() > 0) && kbEn) begin
        sbq.push_back('{kbAddr, {8'h00, m_kbq[0]}}); m_src = 2; m_phase = 1;
      end
    end else if (ph == 1) begin
      if (intAck) begin
        m_phase = 2;
        if (m_src == 0)      m_bp = 0;
        else if (m_src == 1) m_ir = 0;
        else                 void'(m_kbq.pop_front());
      end
    end else if (intDone) begin
      m_phase = 0;
    end
    if ((hit >= 0) && !ob && (ph == 0)) begin m_bp = 1; m_bpIdx = hit; end
    if (irPulse && irEn) m_ir = 1;
    if (m_kbAcc && kbEn) m_kbq.push_back(kbCode);
  endfunction

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic cyc();
    #1;
    chk("kbReady", 32'(kbReady), 32'((m_kbq.size() < 4) || !kbEn));
    model_step();
    @(negedge clk);
    if (m_kbAcc) kbValid = 1'b0;
  endtask

  task automatic quiet();
    pcValid = 0; irPulse = 0; kbValid = 0; intAck = 0; intDone = 0;
  endtask

  task automatic serve();
    int n;
    n = 0;
    while ((m_phase != 1) && (n < 60)) begin cyc(); n++; end
    if (m_phase != 1) begin
      total++; bad++;
      $display("FAIL serve_timeout: phase %0d required 1", m_phase);
    end else begin
      intAck = 1; cyc(); intAck = 0;
      intDone = 1; cyc(); intDone = 0;
      cyc();
    end
  endtask

  // Monitor: compare on every request rise, and vector stability while held.
  initial begin
    mon_prev = 1'b0;
    mon_cur  = '{32'h0, 16'h0};
    forever begin
      @(posedge clk); #1;
      chk("intReq", 32'(intReq), 32'(m_phase == 1));
      if (intReq && !mon_prev) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: vector %h data %h, required no request", intVector, intData);
        end else begin
          mon_cur = sbq.pop_front();
          chk("intData", 32'(intData), 32'(mon_cur.d));
        end
      end
      if (intReq) chk("intVector", intVector, mon_cur.v);
      mon_prev = intReq;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t over limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    addrs[0] = 32'h40; addrs[1] = 32'h120; addrs[2] = 32'h200; addrs[3] = 32'h300;
    rst = 0;
    quiet();
    pc = 0; kbCode = 0; kbEn = 1; irEn = 1;
    for (int i = 0; i < 4; i++) begin bpa[i] = 32'hFFFF_0000 + 32'(i); bpe[i] = 0; end
    bpAddr = 32'hB000_0100; irAddr = 32'h1000_0200; kbAddr = 32'h2000_0300;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_intReq", 32'(intReq), 0);
    chk("rst_intVector", intVector, 0);
    chk("rst_intData", 32'(intData), 0);
    chk("rst_kbReady", 32'(kbReady), 1);
    rst = 1;

    // 1: single breakpoint hit on bp1
    bpe[1] = 1; bpa[1] = 32'h120; pc = 32'h120; pcValid = 1;
    cyc(); pcValid = 0;
    serve();
    chk("t1_intReq_low", 32'(intReq), 0);

    // 2: two breakpoints on the same address, lowest index wins
    bpe[1] = 0; bpa[0] = 32'h40; bpa[2] = 32'h40; bpe[0] = 1; bpe[2] = 1;
    pc = 32'h40; pcValid = 1;
    cyc(); pcValid = 0;
    serve();

    // 3: IR and keyboard together, IR first
    irPulse = 1; kbValid = 1; kbCode = 8'h1C;
    cyc(); irPulse = 0;
    serve();
    serve();

    // 4: overfill the keyboard FIFO, then drain in order
    for (int i = 0; i < 5; i++) begin
      kbValid = 1; kbCode = 8'(8'hA0 + i);
      n = 0;
      while (kbValid && (n < 4)) begin cyc(); n++; end
    end
    for (int i = 0; i < 5; i++) serve();
    chk("t4_kb5_taken", 32'(kbValid), 0);

    // 5: disabled keyboard swallows codes, disabled IR drops pulses
    kbEn = 0; irEn = 0;
    for (int i = 0; i < 6; i++) begin
      kbValid = 1; kbCode = 8'(8'h50 + i); irPulse = 1;
      cyc();
    end
    quiet(); kbEn = 1; irEn = 1;
    cyc(); cyc();
    chk("t5_no_req", 32'(intReq), 0);

    // 6: asynchronous reset while a request is up
    irPulse = 1; cyc(); irPulse = 0;
    n = 0;
    while ((m_phase != 1) && (n < 10)) begin cyc(); n++; end
    chk("t6_req_up", 32'(intReq), 1);
    #2 rst = 0;
    #1;
    chk("t6_async_intReq", 32'(intReq), 0);
    chk("t6_async_intVector", intVector, 0);
    chk("t6_async_intData", 32'(intData), 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    cyc(); cyc(); cyc();
    chk("t6_post_vector", intVector, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      pcValid = 1'($urandom_range(0, 1));
      pc = addrs[$urandom_range(0, 3)];
      if ($urandom_range(0, 31) == 0) begin
        n = $urandom_range(0, 3);
        bpa[n] = addrs[$urandom_range(0, 3)];
        bpe[n] = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) bpAddr = $urandom;
      if ($urandom_range(0, 15) == 0) irAddr = $urandom;
      if ($urandom_range(0, 15) == 0) kbAddr = $urandom;
      irEn    = ($urandom_range(0, 7) != 0);
      irPulse = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 63) == 0) kbEn = !kbEn;
      if (!kbValid && ($urandom_range(0, 2) == 0)) begin
        kbValid = 1; kbCode = 8'($urandom);
      end
      intAck  = 1'($urandom_range(0, 1));
      intDone = ($urandom_range(0, 2) == 0);
      cyc();
    end

    // drain everything still pending
    quiet(); kbEn = 1;
    for (int i = 0; i < 400; i++) begin
      intAck  = (m_phase == 1);
      intDone = (m_phase == 2);
      cyc();
      if ((m_phase == 0) && !m_bp && !m_ir && (m_kbq.size() == 0)) break;
    end
    quiet();
    cyc(); cyc();
    chk("scoreboard_empty", 32'(sbq.size()), 0);
    chk("final_intReq", 32'(intReq), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
